// File: rtl/cpu_bus_bridge_6502_pkg.sv
// Shared definitions for the 6502 memory-access bridge: FSM states, region
// select and the address map constants.
package pif_6502_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMemIssue,
        StMemWait,
        StIoWait,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_e;

    localparam logic [15:0] ROM_BASE      = 16'hF000;
    localparam int unsigned ROM_SIZE_LOG2 = 12;
    localparam logic [15:0] RAM_BASE      = 16'h0000;
    localparam int unsigned RAM_SIZE_LOG2 = 11;
    localparam logic [15:0] IO_BASE       = 16'h4000;
    localparam int unsigned IO_SIZE_LOG2  = 8;
    localparam logic [7:0]  IO_TIMEOUT    = 8'd255;
    localparam logic [7:0]  UNMAP_DATA    = 8'hFF;

    // Windows are naturally aligned, so a match is equality above the size bits.
    function automatic logic in_window(logic [15:0] addr, logic [15:0] base,
                                       int unsigned size_log2);
        return (addr >> size_log2) == (base >> size_log2);
    endfunction

endpackage

// File: rtl/cpu_bus_bridge_6502_if.sv
// CPU-side request/acknowledge bus of the 6502 memory bridge.
interface cpu_bus_bridge_6502_if;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata,
        input  cpu_rdy, cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
        output cpu_rdy, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/cpu_bus_bridge_6502_decode.sv
// Combinational address decoder: CPU address to region and local addresses.
module bus_decode_6502
    import pif_6502_pkg::*;
(
    input  logic [15:0] addr,
    output region_e     region,
    output logic [11:0] rom_addr,
    output logic [10:0] ram_addr,
    output logic [7:0]  io_addr
);

    always_comb begin
        if (in_window(addr, ROM_BASE, ROM_SIZE_LOG2)) begin
            region = REG_ROM;
        end else if (in_window(addr, IO_BASE, IO_SIZE_LOG2)) begin
            region = REG_IO;
        end else if (in_window(addr, RAM_BASE, RAM_SIZE_LOG2)) begin
            region = REG_RAM;
        end else begin
            region = REG_NONE;
        end
    end

    assign rom_addr = addr[11:0];
    assign ram_addr = addr[10:0];
    assign io_addr  = addr[7:0];

endmodule

// File: rtl/cpu_bus_bridge_6502.sv
// Memory-access sequencer between the 6502 core and its boot ROM, work RAM
// and I/O window; stalls the CPU via cpu_rdy until each access completes.
module cpu_bus_bridge_6502
    import pif_6502_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    cpu_bus_bridge_6502_if.slave  bus,
    output logic [11:0]           rom_addr,
    output logic                  rom_oe,
    input  logic                  rom_valid,
    input  logic [7:0]            rom_q,
    output logic [10:0]           ram_addr,
    output logic                  ram_oe,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic                  ram_valid,
    input  logic [7:0]            ram_q,
    output logic                  io_req,
    output logic                  io_we,
    output logic [7:0]            io_addr,
    output logic [7:0]            io_wdata,
    input  logic                  io_ack,
    input  logic [7:0]            io_rdata,
    output logic                  err_rom_write,
    output logic                  err_io_timeout
);

    region_e     dec_region;
    logic [11:0] dec_rom_addr;
    logic [10:0] dec_ram_addr;
    logic [7:0]  dec_io_addr;

    bus_decode_6502 u_decode (
        .addr     (bus.cpu_addr),
        .region   (dec_region),
        .rom_addr (dec_rom_addr),
        .ram_addr (dec_ram_addr),
        .io_addr  (dec_io_addr)
    );

    state_e      state_q, state_d;
    region_e     region_q, region_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [11:0] rom_addr_q, rom_addr_d;
    logic [10:0] ram_addr_q, ram_addr_d;
    logic [7:0]  io_addr_q, io_addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdy_q, rdy_d;
    logic        ack_q, ack_d;
    logic        rom_oe_q, rom_oe_d;
    logic        ram_oe_q, ram_oe_d;
    logic        ram_we_q, ram_we_d;
    logic        io_req_q, io_req_d;
    logic        err_rom_q, err_rom_d;
    logic        err_to_q, err_to_d;

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rom_addr_d = rom_addr_q;
        ram_addr_d = ram_addr_q;
        io_addr_d  = io_addr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rdy_d      = rdy_q;
        io_req_d   = io_req_q;
        ack_d      = 1'b0;
        rom_oe_d   = 1'b0;
        ram_oe_d   = 1'b0;
        ram_we_d   = 1'b0;
        err_rom_d  = 1'b0;
        err_to_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    region_d   = dec_region;
                    we_d       = bus.cpu_we;
                    wdata_d    = bus.cpu_wdata;
                    rom_addr_d = dec_rom_addr;
                    ram_addr_d = dec_ram_addr;
                    io_addr_d  = dec_io_addr;
                    cnt_d      = 8'd0;
                    rdy_d      = 1'b0;
                    unique case (dec_region)
                        REG_ROM: begin
                            if (bus.cpu_we) begin
                                err_rom_d = 1'b1;
                                ack_d     = 1'b1;
                                state_d   = StDone;
                            end else begin
                                rom_oe_d = 1'b1;
                                state_d  = StMemIssue;
                            end
                        end
                        REG_RAM: begin
                            if (bus.cpu_we) begin
                                ram_we_d = 1'b1;
                                ack_d    = 1'b1;
                                state_d  = StDone;
                            end else begin
                                ram_oe_d = 1'b1;
                                state_d  = StMemIssue;
                            end
                        end
                        REG_IO: begin
                            io_req_d = 1'b1;
                            state_d  = StIoWait;
                        end
                        REG_NONE: begin
                            // Unmapped writes are dropped and leave cpu_rdata alone.
                            if (!bus.cpu_we) begin
                                rdata_d = UNMAP_DATA;
                            end
                            ack_d   = 1'b1;
                            state_d = StDone;
                        end
                    endcase
                end
            end
            StMemIssue: begin
                state_d = StMemWait;
            end
            StMemWait: begin
                if (region_q == REG_ROM && rom_valid) begin
                    rdata_d = rom_q;
                    ack_d   = 1'b1;
                    state_d = StDone;
                end else if (region_q == REG_RAM && ram_valid) begin
                    rdata_d = ram_q;
                    ack_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StIoWait: begin
                if (io_ack) begin
                    if (!we_q) begin
                        rdata_d = io_rdata;
                    end
                    io_req_d = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = StDone;
                end else if (cnt_q == IO_TIMEOUT - 8'd1) begin
                    // IO_TIMEOUT cycles of io_req without io_ack: force completion.
                    if (!we_q) begin
                        rdata_d = UNMAP_DATA;
                    end
                    io_req_d = 1'b0;
                    err_to_d = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                rdy_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            region_q   <= REG_NONE;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            rom_addr_q <= 12'h000;
            ram_addr_q <= 11'h000;
            io_addr_q  <= 8'h00;
            cnt_q      <= 8'd0;
            rdata_q    <= 8'h00;
            rdy_q      <= 1'b1;
            ack_q      <= 1'b0;
            rom_oe_q   <= 1'b0;
            ram_oe_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            io_req_q   <= 1'b0;
            err_rom_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rom_addr_q <= rom_addr_d;
            ram_addr_q <= ram_addr_d;
            io_addr_q  <= io_addr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rdy_q      <= rdy_d;
            ack_q      <= ack_d;
            rom_oe_q   <= rom_oe_d;
            ram_oe_q   <= ram_oe_d;
            ram_we_q   <= ram_we_d;
            io_req_q   <= io_req_d;
            err_rom_q  <= err_rom_d;
            err_to_q   <= err_to_d;
        end
    end

    assign bus.cpu_rdy   = rdy_q;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;

    assign rom_addr       = rom_addr_q;
    assign rom_oe         = rom_oe_q;
    assign ram_addr       = ram_addr_q;
    assign ram_oe         = ram_oe_q;
    assign ram_we         = ram_we_q;
    assign ram_wdata      = wdata_q;
    assign io_req         = io_req_q;
    assign io_we          = we_q;
    assign io_addr        = io_addr_q;
    assign io_wdata       = wdata_q;
    assign err_rom_write  = err_rom_q;
    assign err_io_timeout = err_to_q;

endmodule

// File: tb/tb_cpu_bus_bridge_6502.sv
// Directed bench for cpu_bus_bridge_6502 with behavioural ROM/RAM models and a
// bench-driven I/O responder.
module tb_cpu_bus_bridge_6502;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_bus_bridge_6502_if bus ();

    logic [11:0] rom_addr;
    logic        rom_oe, rom_valid, rom_valid_m, rom_valid_inj;
    logic [7:0]  rom_q;
    logic [10:0] ram_addr;
    logic        ram_oe, ram_we, ram_valid;
    logic [7:0]  ram_wdata, ram_q;
    logic        io_req, io_we, io_ack;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    logic        err_rom_write, err_io_timeout;

    cpu_bus_bridge_6502 dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .rom_addr       (rom_addr),
        .rom_oe         (rom_oe),
        .rom_valid      (rom_valid),
        .rom_q          (rom_q),
        .ram_addr       (ram_addr),
        .ram_oe         (ram_oe),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_valid      (ram_valid),
        .ram_q          (ram_q),
        .io_req         (io_req),
        .io_we          (io_we),
        .io_addr        (io_addr),
        .io_wdata       (io_wdata),
        .io_ack         (io_ack),
        .io_rdata       (io_rdata),
        .err_rom_write  (err_rom_write),
        .err_io_timeout (err_io_timeout)
    );

    // Memory models: registered oe -> valid with q one cycle later.
    logic [7:0] rom_mem [4096];
    logic [7:0] ram_mem [2048];

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i) ^ 8'h5C;
        rom_mem[12'hFFC] = 8'hA5;
        for (int i = 0; i < 2048; i++) ram_mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        rom_valid_m <= rom_oe;
        rom_q       <= rom_mem[rom_addr];
        ram_valid   <= ram_oe;
        ram_q       <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    assign rom_valid = rom_valid_m | rom_valid_inj;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         ack_cnt, rom_oe_cnt, ram_oe_cnt, ram_we_cnt, io_req_cnt, err_rom_cnt, err_to_cnt;
    logic [11:0] rom_addr_seen;
    logic [10:0] ram_addr_seen;
    logic [7:0]  ram_wdata_seen, io_addr_seen, io_wdata_seen;
    logic        io_we_seen;

    task automatic clear_counts();
        ack_cnt = 0; rom_oe_cnt = 0; ram_oe_cnt = 0; ram_we_cnt = 0;
        io_req_cnt = 0; err_rom_cnt = 0; err_to_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (bus.cpu_ack) ack_cnt++;
        if (rom_oe) begin rom_oe_cnt++; rom_addr_seen = rom_addr; end
        if (ram_oe) ram_oe_cnt++;
        if (ram_we) begin ram_we_cnt++; ram_addr_seen = ram_addr; ram_wdata_seen = ram_wdata; end
        if (io_req) begin
            io_req_cnt++; io_we_seen = io_we; io_addr_seen = io_addr; io_wdata_seen = io_wdata;
        end
        if (err_rom_write) err_rom_cnt++;
        if (err_io_timeout) err_to_cnt++;
    end

    // One CPU access started at a negedge; lat = cycle after the request edge in which
    // cpu_ack is high (0 if never). req held for `hold` cycles; io_ack pulsed in cycle io_at.
    task automatic access(input string tag, input logic [15:0] addr, input logic we,
                          input logic [7:0] wd, input int hold, input int io_at,
                          output int lat);
        clear_counts();
        bus.cpu_req = 1'b1; bus.cpu_addr = addr; bus.cpu_we = we; bus.cpu_wdata = wd;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 300 && lat == 0; n++) begin
            @(negedge clk);
            if (n == hold) bus.cpu_req = 1'b0;
            io_ack = (io_at != 0 && n == io_at);
            if (bus.cpu_ack) lat = n;
        end
        bus.cpu_req = 1'b0;
        io_ack = 1'b0;
        @(negedge clk);
        check_eq({tag, " rdy after ack"}, 32'(bus.cpu_rdy), 32'd1);
    endtask

    int lat;

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
        io_ack = 1'b0; io_rdata = 8'h00; rom_valid_inj = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("reset rdy", 32'(bus.cpu_rdy), 32'd1);
        check_eq("reset ack", 32'(bus.cpu_ack), 32'd0);
        check_eq("reset rdata", 32'(bus.cpu_rdata), 32'h00);
        check_eq("reset rom_oe", 32'(rom_oe), 32'd0);
        check_eq("reset ram_we", 32'(ram_we), 32'd0);
        check_eq("reset io_req", 32'(io_req), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ROM reads
        access("rom rd fffc", 16'hFFFC, 1'b0, 8'h00, 1, 0, lat);
        check_eq("rom rd lat", 32'(lat), 32'd3);
        check_eq("rom rd data", 32'(bus.cpu_rdata), 32'hA5);
        check_eq("rom rd oe cnt", 32'(rom_oe_cnt), 32'd1);
        check_eq("rom rd addr", 32'(rom_addr_seen), 32'hFFC);
        access("rom rd f123", 16'hF123, 1'b0, 8'h00, 1, 0, lat);
        check_eq("rom rd2 data", 32'(bus.cpu_rdata), 32'h7F);

        // RAM write then read back
        access("ram wr", 16'h0123, 1'b1, 8'h3C, 1, 0, lat);
        check_eq("ram wr lat", 32'(lat), 32'd1);
        check_eq("ram wr strobe cnt", 32'(ram_we_cnt), 32'd1);
        check_eq("ram wr addr", 32'(ram_addr_seen), 32'h123);
        check_eq("ram wr data", 32'(ram_wdata_seen), 32'h3C);
        check_eq("ram wr rdata kept", 32'(bus.cpu_rdata), 32'h7F);
        access("ram rd", 16'h0123, 1'b0, 8'h00, 1, 0, lat);
        check_eq("ram rd lat", 32'(lat), 32'd3);
        check_eq("ram rd data", 32'(bus.cpu_rdata), 32'h3C);
        check_eq("ram rd oe cnt", 32'(ram_oe_cnt), 32'd1);

        // ROM write is an error, no ROM strobe
        access("rom wr", 16'hF010, 1'b1, 8'h55, 1, 0, lat);
        check_eq("rom wr lat", 32'(lat), 32'd1);
        check_eq("rom wr err cnt", 32'(err_rom_cnt), 32'd1);
        check_eq("rom wr oe cnt", 32'(rom_oe_cnt), 32'd0);
        check_eq("rom wr rdata kept", 32'(bus.cpu_rdata), 32'h3C);

        // Unmapped read and write (0x0800 is just past the RAM window)
        access("unmap rd", 16'h2000, 1'b0, 8'h00, 1, 0, lat);
        check_eq("unmap rd lat", 32'(lat), 32'd1);
        check_eq("unmap rd data", 32'(bus.cpu_rdata), 32'hFF);
        access("unmap wr", 16'h0800, 1'b1, 8'h11, 1, 0, lat);
        check_eq("unmap wr lat", 32'(lat), 32'd1);
        check_eq("unmap wr ram_we cnt", 32'(ram_we_cnt), 32'd0);
        check_eq("unmap wr rdata kept", 32'(bus.cpu_rdata), 32'hFF);

        // I/O read acked in cycle 5
        io_rdata = 8'h5A;
        access("io rd", 16'h4007, 1'b0, 8'h00, 1, 5, lat);
        check_eq("io rd lat", 32'(lat), 32'd6);
        check_eq("io rd data", 32'(bus.cpu_rdata), 32'h5A);
        check_eq("io rd addr", 32'(io_addr_seen), 32'h07);
        check_eq("io rd we", 32'(io_we_seen), 32'd0);
        check_eq("io rd req cycles", 32'(io_req_cnt), 32'd5);

        // I/O read never acked: forced completion after 255 cycles of io_req
        access("io timeout", 16'h4007, 1'b0, 8'h00, 1, 0, lat);
        check_eq("io to lat", 32'(lat), 32'd256);
        check_eq("io to data", 32'(bus.cpu_rdata), 32'hFF);
        check_eq("io to err cnt", 32'(err_to_cnt), 32'd1);
        check_eq("io to req cycles", 32'(io_req_cnt), 32'd255);

        // I/O write acked in cycle 2
        access("io wr", 16'h4010, 1'b1, 8'h77, 1, 2, lat);
        check_eq("io wr lat", 32'(lat), 32'd3);
        check_eq("io wr we", 32'(io_we_seen), 32'd1);
        check_eq("io wr data", 32'(io_wdata_seen), 32'h77);
        check_eq("io wr err cnt", 32'(err_to_cnt), 32'd0);

        // cpu_req held through the busy period -> exactly one access
        access("held req", 16'hFFFC, 1'b0, 8'h00, 3, 0, lat);
        repeat (4) @(negedge clk);
        check_eq("held req lat", 32'(lat), 32'd3);
        check_eq("held req ack cnt", 32'(ack_cnt), 32'd1);
        check_eq("held req oe cnt", 32'(rom_oe_cnt), 32'd1);

        // Reset while waiting for ROM data, then a stray rom_valid
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'hFFFC; bus.cpu_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst rdy", 32'(bus.cpu_rdy), 32'd1);
        check_eq("midrst ack", 32'(bus.cpu_ack), 32'd0);
        check_eq("midrst rdata", 32'(bus.cpu_rdata), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        clear_counts();
        @(negedge clk);
        rom_valid_inj = 1'b1;
        @(negedge clk);
        rom_valid_inj = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("late valid ack cnt", 32'(ack_cnt), 32'd0);
        check_eq("late valid rdy", 32'(bus.cpu_rdy), 32'd1);
        access("post rst rd", 16'hF123, 1'b0, 8'h00, 1, 0, lat);
        check_eq("post rst lat", 32'(lat), 32'd3);
        check_eq("post rst data", 32'(bus.cpu_rdata), 32'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
